mem_responder: RTL and testbench
================================

# mem_responder

Word-addressed data-memory responder: the target end of the CPU's load/store interface. Accepts one request at a time over a valid/ready handshake, waits a fixed access latency, commits the write or captures the read, and returns a registered response over a second valid/ready handshake. Sits between the CPU datapath's memory stage and the memory array. It replaces the zero-latency ideal memory, so stall logic can be exercised.

## Interface
- ADDR_WIDTH, 10, word-address bits; the array holds 2^ADDR_WIDTH 32-bit words
- LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_wr_en  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_byte_en  in  4  store lane enables; bit i covers wdata[8i+7:8i]
- resp_valid  out  1  response present
- resp_ready  in  1  initiator accepts response
- resp_rdata  out  32  load data; 0 for stores and errors
- resp_err  out  1  request was misaligned or out of range

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch addr, wdata, wr_en and byte_en, and load the counter with LATENCY-1.
  - If LATENCY == 1, go directly to the commit step; otherwise go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, commit and go to RESP.
- Commit, in a single edge:
  - Error check: err = (addr[1:0] != 0) || (addr[31:ADDR_WIDTH+2] != 0).
  - No error, store: write enabled lanes at word addr[ADDR_WIDTH+1:2]; resp_rdata = 0.
  - No error, load: resp_rdata = full word; byte_en is ignored.
  - Error: no array write; resp_rdata = 0; resp_err = 1.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err stay stable.
  - On resp_ready, go to IDLE and clear resp_valid, resp_rdata and resp_err.
- Only one request is outstanding at a time. req_ready is 0 in WAIT and RESP.
- Request inputs are ignored outside the accept handshake.
- Array contents are not cleared by reset. Initial contents are undefined.

## Timing
- Reset values, all outputs: req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0. The counter is reset to 0.
- Request accepted at edge k:
  - resp_valid rises after edge k+LATENCY.
  - A store's array write takes effect at that same edge.
- Response handshake at edge m: req_ready rises after edge m. There is no same-cycle bypass.
- Minimum request-to-request spacing is LATENCY+2 cycles.
- Reset asserted in WAIT: abort and go to IDLE; the pending store is not written.
- Reset asserted in RESP: the already-committed store persists; the response is dropped.
- resp_ready held low: stay in RESP indefinitely with outputs frozen.
- req_valid asserted in RESP: not accepted until after the response handshake.

## Structure
- Package mem_pkg holds:
  - the state enum (IDLE, WAIT, RESP)
  - WORD_BYTES = 4
  - the counter width constant (4 bits)
- Sub-module mem_array holds the word array:
  - one synchronous write port with 4-bit byte lanes
  - one asynchronous read port
- mem_responder holds the FSM, the request latches, the latency counter, the error check and the response register.

## Test plan
- Store then load, LATENCY=2:
  - Store addr 0x10, wdata 0xDEADBEEF, byte_en 4'hF; resp_valid 2 cycles after accept, rdata 0, err 0.
  - Load addr 0x10 -> rdata 0xDEADBEEF, err 0.
- Partial store:
  - Preload 0xDEADBEEF at 0x10; store wdata 0x00000055 with byte_en 4'b0001.
  - Load 0x10 -> 0xDEADBE55.
- Errors:
  - Load addr 0x12 -> err 1, rdata 0.
  - Store addr 0x00001000 (ADDR_WIDTH=10) -> err 1; a following load of 0x0 is unchanged.
- Backpressure:
  - Hold resp_ready low for 5 cycles after resp_valid; resp_valid and rdata stay stable, req_ready stays 0.
  - req_ready rises the cycle after the handshake.
- Reset mid-WAIT:
  - Store 0xCAFEF00D to 0x20 after a prior value of 0x11111111; assert reset 1 cycle after accept.
  - Outputs return to reset values; a load of 0x20 -> 0x11111111.
- LATENCY=1 back-to-back:
  - Continuous req_valid with resp_ready=1; one request accepted every 3 cycles.
  - Each response appears 1 cycle after its accept.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int CNT_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } stateT;

  // A request is rejected when it is not word aligned or when it addresses
  // beyond the array (any byte-address bit above the word index is set).
  function automatic logic addrError(input logic [31:0] addr, input int unsigned addrWidth);
    return (addr[1:0] != 2'b00) || ((addr >> (addrWidth + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Load/store request and response channels between the CPU memory stage
// (master) and the memory responder (slave).
interface mem_responder_if
  import mem_pkg::*;
;
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_wr_en;
  logic [31:0]             req_addr;
  logic [31:0]             req_wdata;
  logic [WORD_BYTES-1:0]   req_byte_en;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [31:0]             resp_rdata;
  logic                    resp_err;

  modport master (
    output req_valid, req_wr_en, req_addr, req_wdata, req_byte_en, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wr_en, req_addr, req_wdata, req_byte_en, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_array.sv
// Word array: one synchronous byte-lane write port, one asynchronous read port.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      wrEn,
  input  logic [ADDR_WIDTH-1:0]     wrAddr,
  input  logic [8*WORD_BYTES-1:0]   wrData,
  input  logic [WORD_BYTES-1:0]     byteEn,
  input  logic [ADDR_WIDTH-1:0]     rdAddr,
  output logic [8*WORD_BYTES-1:0]   rdData
);

  logic [8*WORD_BYTES-1:0] mem [2**ADDR_WIDTH];

  // Write the enabled byte lanes of the addressed word.
  // NOTE: the array has no reset -- contents survive reset so a store that
  // has already committed persists, and it keeps the array mappable to RAM.
  // NOTE: non-blocking assignments for all clocked state so every reader of
  // the array sees the pre-edge value within the same edge.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (byteEn[i]) begin
          mem[wrAddr][8*i +: 8] <= wrData[8*i +: 8];
        end
      end
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY
// cycles, commits to the array and holds a registered response until taken.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2   // legal range 1..15
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);

  localparam int DATA_WIDTH = 8 * WORD_BYTES;

  stateT                  state;
  stateT                  stateNext;
  logic [CNT_WIDTH-1:0]   cnt;

  logic [31:0]            addrQ;
  logic [DATA_WIDTH-1:0]  wdataQ;
  logic                   wrEnQ;
  logic [WORD_BYTES-1:0]  byteEnQ;

  logic [DATA_WIDTH-1:0]  respRdata;
  logic                   respErr;

  logic                   accept;
  logic                   commit;
  logic                   cmtErr;
  logic                   arrWrEn;
  logic [ADDR_WIDTH-1:0]  wordAddr;
  logic [DATA_WIDTH-1:0]  arrRdata;

  assign accept   = bus.req_valid && (state == IDLE);
  assign cmtErr   = addrError(addrQ, ADDR_WIDTH);
  assign wordAddr = addrQ[ADDR_WIDTH+1:2];
  assign arrWrEn  = commit && wrEnQ && !cmtErr;

  mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .wrEn  (arrWrEn),
    .wrAddr(wordAddr),
    .wrData(wdataQ),
    .byteEn(byteEnQ),
    .rdAddr(wordAddr),
    .rdData(arrRdata)
  );

  // State register; reset abandons any request still waiting to commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and commit strobe. Every accept goes through WAIT: with
  // LATENCY == 1 the counter is loaded with 0, so the commit happens on the
  // very next edge and the response still appears LATENCY edges after accept.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    stateNext = state;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          commit    = 1'b1;
          stateNext = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Request latches, latency counter and the registered response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      addrQ     <= '0;
      wdataQ    <= '0;
      wrEnQ     <= 1'b0;
      byteEnQ   <= '0;
      respRdata <= '0;
      respErr   <= 1'b0;
    end else begin
      if (accept) begin
        addrQ   <= bus.req_addr;
        wdataQ  <= bus.req_wdata;
        wrEnQ   <= bus.req_wr_en;
        byteEnQ <= bus.req_byte_en;
        cnt     <= CNT_WIDTH'(LATENCY - 1);
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - CNT_WIDTH'(1);
      end

      if (commit) begin
        respErr   <= cmtErr;
        respRdata <= (cmtErr || wrEnQ) ? '0 : arrRdata;
      end else if ((state == RESP) && bus.resp_ready) begin
        respErr   <= 1'b0;
        respRdata <= '0;
      end
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = respRdata;
  assign bus.resp_err   = respErr;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance at LATENCY=2 (directed + random
// traffic with random backpressure) and one at LATENCY=1 (continuous
// back-to-back requests). Expected responses come from a byte-addressed
// reference model and are queued at accept time; monitors compare them when
// the responder hands a response over.
module tb_mem_responder;

  localparam int          AW          = 10;
  localparam logic [31:0] SPACE_BYTES = 32'(4 << AW);

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } respT;

  logic clk = 1'b0;
  logic rst2;
  logic rst1;
  int   cyc     = 0;
  int   nChecks = 0;
  int   nFail   = 0;
  bit   done1   = 1'b0;
  bit   done2   = 1'b0;
  bit   bpHold  = 1'b0;
  bit   bpForce = 1'b0;

  logic [7:0] mem2 [bit [31:0]];
  logic [7:0] mem1 [bit [31:0]];
  respT       exp2 [$];
  respT       exp1 [$];
  int         acc2 [$];
  int         acc1 [$];

  mem_responder_if bus2 ();
  mem_responder_if bus1 ();

  mem_responder #(.ADDR_WIDTH(AW), .LATENCY(2)) dut2 (
    .clk  (clk),
    .reset(rst2),
    .bus  (bus2.slave)
  );

  mem_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) dut1 (
    .clk  (clk),
    .reset(rst1),
    .bus  (bus1.slave)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte-addressed memory, one entry per byte written.
  function automatic respT refAccess(input bit sel1, input bit wr, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [3:0] be);
    respT r;
    r.err   = (addr % 4 != 0) || (addr >= SPACE_BYTES);
    r.rdata = 32'h0;
    if (!r.err) begin
      for (int i = 0; i < 4; i++) begin
        bit [31:0] b;
        b = addr + 32'(i);
        if (wr) begin
          if (be[i]) begin
            if (sel1) mem1[b] = wdata[8*i +: 8];
            else      mem2[b] = wdata[8*i +: 8];
          end
        end else if (sel1) begin
          r.rdata[8*i +: 8] = mem1.exists(b) ? mem1[b] : 8'hxx;
        end else begin
          r.rdata[8*i +: 8] = mem2.exists(b) ? mem2[b] : 8'hxx;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] randAddr(input int words);
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'($urandom_range(0, words - 1)) * 4 + 32'($urandom_range(1, 3));
    if (r == 1) return SPACE_BYTES + 32'($urandom_range(0, 4095)) * 4;
    if (r == 2) return 32'h8000_0000 | (32'($urandom_range(0, words - 1)) * 4);
    return 32'($urandom_range(0, words - 1)) * 4;
  endfunction

  // Issue one request to the LATENCY=2 instance; returns just after accept.
  task automatic req2(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input bit track);
    int waited;
    waited = 0;
    @(posedge clk); #1;
    bus2.req_valid   = 1'b1;
    bus2.req_wr_en   = wr;
    bus2.req_addr    = addr;
    bus2.req_wdata   = wdata;
    bus2.req_byte_en = be;
    forever begin
      @(negedge clk);
      if (bus2.req_ready || waited > 200) break;
      waited++;
    end
    check("dut2_accept", bus2.req_ready, 1'b1);
    if (track) exp2.push_back(refAccess(1'b0, wr, addr, wdata, be));
    @(posedge clk); #1;
    // Garbage on the request lines outside the handshake must be ignored.
    bus2.req_valid   = 1'b0;
    bus2.req_wr_en   = 1'b1;
    bus2.req_addr    = $urandom;
    bus2.req_wdata   = $urandom;
    bus2.req_byte_en = 4'hF;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_req_ready"},  bus2.req_ready,  1'b1);
    check({tag, "_resp_valid"}, bus2.resp_valid, 1'b0);
    check({tag, "_resp_rdata"}, bus2.resp_rdata, 32'h0);
    check({tag, "_resp_err"},   bus2.resp_err,   1'b0);
  endtask

  // resp_ready for the LATENCY=2 instance: random unless a test pins it.
  initial begin
    bus2.resp_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus2.resp_ready = bpHold ? 1'b0 : (bpForce ? 1'b1 : ($urandom_range(0, 3) != 0));
    end
  end

  // Monitor, LATENCY=2 instance.
  initial begin
    bit   prevValid;
    respT e;
    prevValid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst2 !== 1'b0) begin
        prevValid = 1'b0;
      end else begin
        if (bus2.req_valid && bus2.req_ready) acc2.push_back(cyc + 1);
        if (bus2.resp_valid && !prevValid) begin
          if (acc2.size() == 0) check("dut2_unexpected_valid", bus2.resp_valid, 1'b0);
          else check("dut2_latency", 32'(cyc - acc2.pop_front()), 32'd2);
        end
        if (bus2.resp_valid && bus2.resp_ready) begin
          if (exp2.size() == 0) begin
            check("dut2_unexpected_resp", bus2.resp_valid, 1'b0);
          end else begin
            e = exp2.pop_front();
            check("dut2_rdata", bus2.resp_rdata, e.rdata);
            check("dut2_err",   bus2.resp_err,   e.err);
          end
        end
        prevValid = bus2.resp_valid;
      end
    end
  end

  // Stimulus, LATENCY=2 instance.
  initial begin
    int n;
    rst2             = 1'b1;
    bus2.req_valid   = 1'b0;
    bus2.req_wr_en   = 1'b0;
    bus2.req_addr    = 32'h0;
    bus2.req_wdata   = 32'h0;
    bus2.req_byte_en = 4'h0;
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk); #1;
    rst2 = 1'b0;

    // Store then load, partial store.
    req2(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    req2(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    req2(1'b1, 32'h10, 32'h00000055, 4'b0001, 1'b1);
    req2(1'b0, 32'h10, 32'h0, 4'hF, 1'b1);

    // Errors: misaligned load, out-of-range store leaves word 0 alone.
    req2(1'b0, 32'h12, 32'h0, 4'h0, 1'b1);
    req2(1'b1, 32'h0, 32'h12345678, 4'hF, 1'b1);
    req2(1'b1, 32'h00001000, 32'hFFFFFFFF, 4'hF, 1'b1);
    req2(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);

    // Backpressure: response held for 5 cycles, then taken.
    req2(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    bpHold = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus2.resp_valid && n < 20);
    check("bp_valid_seen", bus2.resp_valid, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid_held", bus2.resp_valid, 1'b1);
      check("bp_rdata_held", bus2.resp_rdata, 32'hDEADBE55);
      check("bp_req_ready",  bus2.req_ready,  1'b0);
    end
    bpHold  = 1'b0;
    bpForce = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_no_bypass", bus2.req_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("bp_req_ready_rise", bus2.req_ready,  1'b1);
    check("bp_valid_clear",    bus2.resp_valid, 1'b0);
    check("bp_rdata_clear",    bus2.resp_rdata, 32'h0);
    bpForce = 1'b0;

    // Reset one cycle after accepting a store: the store must not land.
    req2(1'b1, 32'h20, 32'h11111111, 4'hF, 1'b1);
    req2(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0);
    @(posedge clk); #1;
    rst2 = 1'b1;
    @(negedge clk);
    checkResetOutputs("midwait");
    @(posedge clk);
    @(posedge clk); #1;
    acc2.delete();
    rst2 = 1'b0;
    req2(1'b0, 32'h20, 32'h0, 4'h0, 1'b1);

    // Random traffic over 16 initialised words.
    for (int w = 0; w < 16; w++) req2(1'b1, 32'(w * 4), $urandom, 4'hF, 1'b1);
    for (int t = 0; t < 40; t++) begin
      req2(1'($urandom_range(0, 1)), randAddr(16), $urandom, 4'($urandom), 1'b1);
    end

    n = 0;
    while (exp2.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("dut2_drained", 32'(exp2.size()), 32'd0);
    done2 = 1'b1;
  end

  // Monitor, LATENCY=1 instance: latency, accept spacing and data.
  initial begin
    int   lastAcc;
    bit   prevValid;
    respT e;
    lastAcc   = -1;
    prevValid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst1 !== 1'b0) begin
        prevValid = 1'b0;
      end else begin
        if (bus1.req_valid && bus1.req_ready) begin
          if (lastAcc >= 0) check("dut1_spacing", 32'(cyc + 1 - lastAcc), 32'd3);
          lastAcc = cyc + 1;
          acc1.push_back(cyc + 1);
        end
        if (bus1.resp_valid && !prevValid) begin
          if (acc1.size() == 0) check("dut1_unexpected_valid", bus1.resp_valid, 1'b0);
          else check("dut1_latency", 32'(cyc - acc1.pop_front()), 32'd1);
        end
        if (bus1.resp_valid && bus1.resp_ready) begin
          if (exp1.size() == 0) begin
            check("dut1_unexpected_resp", bus1.resp_valid, 1'b0);
          end else begin
            e = exp1.pop_front();
            check("dut1_rdata", bus1.resp_rdata, e.rdata);
            check("dut1_err",   bus1.resp_err,   e.err);
          end
        end
        prevValid = bus1.resp_valid;
      end
    end
  end

  // Stimulus, LATENCY=1 instance: req_valid held high, resp_ready held high.
  initial begin
    int n;
    int waited;
    rst1             = 1'b1;
    bus1.req_valid   = 1'b0;
    bus1.req_wr_en   = 1'b0;
    bus1.req_addr    = 32'h0;
    bus1.req_wdata   = 32'h0;
    bus1.req_byte_en = 4'h0;
    bus1.resp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst1 = 1'b0;
    n = 0;
    waited = 0;
    bus1.req_valid = 1'b1;
    while (n < 30) begin
      if (waited == 0) begin
        if (n < 8) begin
          bus1.req_wr_en   = 1'b1;
          bus1.req_addr    = 32'(n * 4);
          bus1.req_byte_en = 4'hF;
        end else begin
          bus1.req_wr_en   = 1'($urandom_range(0, 1));
          bus1.req_addr    = randAddr(8);
          bus1.req_byte_en = 4'($urandom);
        end
        bus1.req_wdata = $urandom;
      end
      @(negedge clk);
      if (bus1.req_ready) begin
        exp1.push_back(refAccess(1'b1, bus1.req_wr_en, bus1.req_addr,
                                 bus1.req_wdata, bus1.req_byte_en));
        n++;
        waited = 0;
      end else begin
        waited++;
        if (waited > 10) begin
          check("dut1_accept", bus1.req_ready, 1'b1);
          break;
        end
      end
      @(posedge clk); #1;
    end
    bus1.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("dut1_drained", 32'(exp1.size()), 32'd0);
    done1 = 1'b1;
  end

  initial begin
    wait (done1 && done2);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not complete, %0d checks done", nChecks);
    $fatal(1, "watchdog expired");
  end

endmodule
